// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared types and constants for the external-bus fan-out controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ext_bus_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // CSR window word offsets.
  localparam logic [1:0] IRQ_STATUS = 2'd0;
  localparam logic [1:0] IRQ_MASK   = 2'd1;
  localparam logic [1:0] ERR_COUNT  = 2'd2;
  localparam logic [1:0] ERR_ADDR   = 2'd3;

  // Read word returned when a peripheral access times out.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/ext_bus_ctrl_if.sv
// ext_bus_ctrl_if: bridge-side and peripheral-side signals of the fan-out controller.
// Latency: n/a (wiring only).
// Backpressure: bridge holds m_bus_enable until m_acknowledge; peripherals answer with s_acknowledge.
// Modports: slave = the controller (serves the bridge, drives the peripherals);
//           master = the environment (bridge + peripherals) facing the controller.
interface ext_bus_ctrl_if #(
  parameter int N_SLAVES   = 4,
  parameter int ADDR_W     = 9,
  parameter int SLV_ADDR_W = 6
);

  // Bridge side
  logic                     m_bus_enable;
  logic [ADDR_W-1:0]        m_address;
  logic                     m_rw;
  logic [3:0]               m_byte_enable;
  logic [31:0]              m_write_data;
  logic [31:0]              m_read_data;
  logic                     m_acknowledge;
  logic                     m_irq;

  // Peripheral side
  logic [N_SLAVES-1:0]      s_bus_enable;
  logic [SLV_ADDR_W-1:0]    s_address;
  logic                     s_rw;
  logic [3:0]               s_byte_enable;
  logic [31:0]              s_write_data;
  logic [N_SLAVES*32-1:0]   s_read_data;
  logic [N_SLAVES-1:0]      s_acknowledge;
  logic [N_SLAVES-1:0]      s_irq;

  modport slave (
    input  m_bus_enable, m_address, m_rw, m_byte_enable, m_write_data,
    output m_read_data, m_acknowledge, m_irq,
    output s_bus_enable, s_address, s_rw, s_byte_enable, s_write_data,
    input  s_read_data, s_acknowledge, s_irq
  );

  modport master (
    output m_bus_enable, m_address, m_rw, m_byte_enable, m_write_data,
    input  m_read_data, m_acknowledge, m_irq,
    input  s_bus_enable, s_address, s_rw, s_byte_enable, s_write_data,
    output s_read_data, s_acknowledge, s_irq
  );

endinterface

// File: rtl/ext_bus_csr.sv
// ext_bus_csr: IRQ mask, timeout error counter/address, CSR read mux and registered m_irq.
// Latency: register writes land on the strobe edge; read mux is combinational; o_irq lags one cycle.
// Backpressure: none, accepts a strobe every cycle.
// Ports: i_access/i_rw/i_offset/i_mask_wdata = CSR access strobe and fields,
//        i_irq = raw peripheral interrupts, i_timeout/i_err_addr = timeout log strobe,
//        o_rdata = selected CSR value, o_irq = masked interrupt OR.
module ext_bus_csr
  import ext_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_access,
  input  logic                i_rw,
  input  logic [1:0]          i_offset,
  input  logic [N_SLAVES-1:0] i_mask_wdata,
  input  logic [N_SLAVES-1:0] i_irq,
  input  logic                i_timeout,
  input  logic [ADDR_W-1:0]   i_err_addr,
  output logic [31:0]         o_rdata,
  output logic                o_irq
);

  logic [N_SLAVES-1:0] r_mask;
  logic [15:0]         r_err_cnt;
  logic [ADDR_W-1:0]   r_err_addr;
  logic                r_irq;
  logic                w_wr;

  assign w_wr  = i_access & ~i_rw;
  assign o_irq = r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask     <= '0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (i_offset == IRQ_MASK)) begin
        r_mask <= i_mask_wdata;
      end
      // Timeouts and CSR accesses never coincide (one transaction at a time),
      // so the clear-on-write has no real conflict with the increment.
      if (i_timeout) begin
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        r_err_addr <= i_err_addr;
      end else if (w_wr && (i_offset == ERR_COUNT)) begin
        r_err_cnt <= '0;
      end
      r_irq <= |(i_irq & r_mask);
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_offset)
      IRQ_STATUS: o_rdata = 32'(i_irq);
      IRQ_MASK:   o_rdata = 32'(r_mask);
      ERR_COUNT:  o_rdata = 32'(r_err_cnt);
      ERR_ADDR:   o_rdata = 32'(r_err_addr);
    endcase
  end

endmodule

// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: decodes bridge accesses to one of N peripherals or a CSR window, one at a time.
// Latency: peripheral ack at edge k -> m_acknowledge at k+1; CSR ack 2 edges after request; timeout after TIMEOUT cycles.
// Backpressure: bridge holds m_bus_enable until m_acknowledge; a new request is only taken after it drops.
// Ports: clk, rst_n (async active-low); bus = ext_bus_ctrl_if.slave carrying the bridge
//        request/response and the shared, latched peripheral bus with per-slot enable/ack/data/irq.
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int          N_SLAVES   = 4,
  parameter int          ADDR_W     = 9,
  parameter int          SLV_ADDR_W = 6,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  ext_bus_ctrl_if.slave bus
);

  localparam int IDX_W = ADDR_W - SLV_ADDR_W;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [N_SLAVES-1:0] r_onehot;
  logic                r_is_csr;
  logic [15:0]         r_cnt;
  logic [31:0]         r_rdata;

  logic [IDX_W-1:0]    w_idx;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_sel_ack;
  logic [31:0]         w_sel_rdata;
  logic [31:0]         w_csr_rdata;
  logic                w_latch;
  logic                w_done_ack;
  logic                w_done_to;
  logic                w_csr_access;

  // Region decode: any index beyond the last peripheral lands in the CSR window.
  assign w_idx = bus.m_address[ADDR_W-1:SLV_ADDR_W];

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      w_onehot[i] = (int'(w_idx) == i);
    end
  end

  // Only the selected peripheral's ack and read slot are ever looked at.
  assign w_sel_ack = |(bus.s_acknowledge & r_onehot);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      w_sel_rdata = w_sel_rdata | (bus.s_read_data[32*i +: 32] & {32{r_onehot[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_done_ack   = 1'b0;
    w_done_to    = 1'b0;
    w_csr_access = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.m_bus_enable) begin
          w_latch = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_is_csr) begin
          w_csr_access = 1'b1;
          w_next       = RESP;
        end else if (w_sel_ack) begin
          // Checked ahead of the timeout so an ack on the last cycle still wins.
          w_done_ack = 1'b1;
          w_next     = RESP;
        end else if (r_cnt == 16'(TIMEOUT - 1)) begin
          w_done_to = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        w_next = RELEASE;
      end
      RELEASE: begin
        // Hold here until the bridge drops its enable so one request gives one ack.
        if (!bus.m_bus_enable) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_onehot <= '0;
      r_is_csr <= 1'b0;
      r_cnt    <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_latch) begin
        r_addr   <= bus.m_address;
        r_rw     <= bus.m_rw;
        r_be     <= bus.m_byte_enable;
        r_wdata  <= bus.m_write_data;
        r_onehot <= w_onehot;
        r_is_csr <= ~|w_onehot;
        r_cnt    <= '0;
      end else if ((r_state == ACCESS) && !r_is_csr) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_done_ack) begin
        r_rdata <= w_sel_rdata;
      end else if (w_done_to) begin
        r_rdata <= ERR_DATA;
      end else if (w_csr_access) begin
        r_rdata <= w_csr_rdata;
      end
    end
  end

  ext_bus_csr #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W)
  ) u_csr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_access     (w_csr_access),
    .i_rw         (r_rw),
    .i_offset     (r_addr[1:0]),
    .i_mask_wdata (r_wdata[N_SLAVES-1:0]),
    .i_irq        (bus.s_irq),
    .i_timeout    (w_done_to),
    .i_err_addr   (r_addr),
    .o_rdata      (w_csr_rdata),
    .o_irq        (bus.m_irq)
  );

  // Enables come straight off the state register, so reset drops them at once.
  assign bus.s_bus_enable  = ((r_state == ACCESS) && !r_is_csr) ? r_onehot : '0;
  assign bus.s_address     = r_addr[SLV_ADDR_W-1:0];
  assign bus.s_rw          = r_rw;
  assign bus.s_byte_enable = r_be;
  assign bus.s_write_data  = r_wdata;
  assign bus.m_acknowledge = (r_state == RESP);
  assign bus.m_read_data   = r_rdata;

endmodule
